// File: rtl/seg_scan_arbiter.sv
// seg_scan_arbiter: scans one 8-digit seven-segment port and hands the
// display to one of four sources. Ownership changes only on frame
// boundaries, so a source's frame is never torn.
//
// Ports:
//   clock          system clock
//   rst            asynchronous active-low reset
//   req[3:0]       display request per source; bit 0 is the urgent source
//   en_bus[31:0]   digit enable mask per source, active-high (8 bits each)
//   frame[255:0]   active-low segment patterns, source k digit d at [64k+8d +: 8]
//   grant[3:0]     one-hot current owner, 0 when idle
//   targeten[7:0]  digit anodes, active-low
//   targetdisplay  segment pattern of the selected digit
//   frame_end      one-cycle pulse on the last cycle of digit 7
module seg_scan_arbiter #(
  parameter int unsigned SCAN_DIV    = 5000,
  parameter int unsigned HOLD_FRAMES = 4
) (
  input  logic         clock,
  input  logic         rst,
  input  logic [3:0]   req,
  input  logic [31:0]  en_bus,
  input  logic [255:0] frame,
  output logic [3:0]   grant,
  output logic [7:0]   targeten,
  output logic [7:0]   targetdisplay,
  output logic         frame_end
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [8:0] HOLD_LIM = 9'(HOLD_FRAMES);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       select_q, select_d;
  logic [1:0]       owner_q, owner_d;
  logic [7:0]       held_q, held_d;
  logic [1:0]       rr_q, rr_d;

  logic       tick;
  logic [3:0] others;
  logic [8:0] held_inc;
  logic [1:0] win;
  logic [7:0] en_sel;
  logic [7:0] pat_sel;

  // First set bit of r, searching start, start+1, ... modulo 4.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = start + 2'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign tick      = (div_q == DIV_LAST);
  assign frame_end = tick && (select_q == 3'd7);
  assign others    = req & ~(4'b0001 << owner_q);
  assign held_inc  = {1'b0, held_q} + 9'd1;

  // State and scan registers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      div_q    <= '0;
      select_q <= 3'd0;
      owner_q  <= 2'd0;
      held_q   <= 8'd0;
      rr_q     <= 2'd3;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      select_q <= select_d;
      owner_q  <= owner_d;
      held_q   <= held_d;
      rr_q     <= rr_d;
    end
  end

  // Next-state: free-running scanner plus frame-boundary arbitration.
  always_comb begin
    state_d  = state_q;
    div_d    = tick ? '0 : div_q + DIV_W'(1);
    select_d = tick ? select_q + 3'd1 : select_q;
    owner_d  = owner_q;
    held_d   = held_q;
    rr_d     = rr_q;
    win      = 2'd0;

    case (state_q)
      IDLE: begin
        if (req != 4'd0) begin
          win      = req[0] ? 2'd0 : rr_pick(req, rr_q + 2'd1);
          state_d  = SHOW;
          owner_d  = win;
          rr_d     = win;
          held_d   = 8'd0;
          div_d    = '0;
          select_d = 3'd0;
        end
      end
      SHOW: begin
        if (frame_end) begin
          if (req[0] && owner_q != 2'd0) begin
            owner_d = 2'd0;
            rr_d    = 2'd0;
            held_d  = 8'd0;
          end else if (!req[owner_q]) begin
            if (others != 4'd0) begin
              win     = rr_pick(others, owner_q + 2'd1);
              owner_d = win;
              rr_d    = win;
              held_d  = 8'd0;
            end else begin
              state_d = IDLE;
            end
          end else if (held_inc >= HOLD_LIM && others != 4'd0 && owner_q != 2'd0) begin
            // The urgent source is never rotated away while it still requests.
            win     = rr_pick(others, owner_q + 2'd1);
            owner_d = win;
            rr_d    = win;
            held_d  = 8'd0;
          end else begin
            held_d = (held_q == 8'hFF) ? held_q : held_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Owner's live enable and segment data for the current digit.
  assign en_sel  = en_bus[{owner_q, 3'b000} +: 8];
  assign pat_sel = frame[{owner_q, select_q, 3'b000} +: 8];

  always_comb begin
    grant         = 4'd0;
    targeten      = 8'hFF;
    targetdisplay = 8'hFF;
    if (state_q == SHOW) begin
      grant         = 4'b0001 << owner_q;
      targeten      = ~(8'b0000_0001 << select_q) | ~en_sel;
      targetdisplay = pat_sel;
    end
  end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Bench for seg_scan_arbiter: directed scenarios then randomized request
// traffic, every cycle compared against a frame-level reference model.
module tb_seg_scan_arbiter;

  localparam int unsigned SD   = 2;
  localparam int unsigned HF   = 2;
  localparam int unsigned FLEN = 8 * SD;

  logic         clock = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   req = 4'd0;
  logic [31:0]  en_bus = 32'hFFFF_FFFF;
  logic [255:0] frame = '0;
  logic [3:0]   grant;
  logic [7:0]   targeten;
  logic [7:0]   targetdisplay;
  logic         frame_end;

  int checks = 0;
  int errors = 0;

  seg_scan_arbiter #(.SCAN_DIV(SD), .HOLD_FRAMES(HF)) dut (
    .clock(clock), .rst(rst), .req(req), .en_bus(en_bus), .frame(frame),
    .grant(grant), .targeten(targeten), .targetdisplay(targetdisplay),
    .frame_end(frame_end)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within the frame, current owner, hold count.
  bit         m_show = 1'b0;
  int         m_owner = 0;
  int         m_held = 0;
  int         m_rr = 3;
  int         m_phase = 0;
  bit         m_fe;
  logic [3:0] m_oth;

  function automatic int pick(input logic [3:0] r, input int start);
    for (int i = 0; i < 4; i++) begin
      if (r[(start + i) % 4]) return (start + i) % 4;
    end
    return 0;
  endfunction

  always begin
    @(posedge clock or negedge rst);
    if (!rst) begin
      m_show = 1'b0; m_owner = 0; m_held = 0; m_rr = 3; m_phase = 0;
    end else begin
      m_fe    = (m_phase == FLEN - 1);
      m_phase = (m_phase + 1) % FLEN;
      m_oth   = req & ~(4'b0001 << m_owner);
      if (!m_show) begin
        if (req != 4'd0) begin
          m_owner = req[0] ? 0 : pick(req, (m_rr + 1) % 4);
          m_rr = m_owner; m_held = 0; m_phase = 0; m_show = 1'b1;
        end
      end else if (m_fe) begin
        if (req[0] && m_owner != 0) begin
          m_owner = 0; m_rr = 0; m_held = 0;
        end else if (!req[m_owner]) begin
          if (m_oth != 4'd0) begin
            m_owner = pick(m_oth, (m_owner + 1) % 4); m_rr = m_owner; m_held = 0;
          end else begin
            m_show = 1'b0;
          end
        end else if (m_held + 1 >= HF && m_oth != 4'd0 && m_owner != 0) begin
          m_owner = pick(m_oth, (m_owner + 1) % 4); m_rr = m_owner; m_held = 0;
        end else begin
          m_held = (m_held + 1 > 255) ? 255 : m_held + 1;
        end
      end
    end
  end

  task automatic check_outputs();
    int         digit;
    logic [7:0] enb, ee, ed;
    logic [3:0] eg;
    digit = m_phase / SD;
    eg = 4'd0; ee = 8'hFF; ed = 8'hFF;
    if (m_show) begin
      eg  = 4'(1 << m_owner);
      enb = en_bus[m_owner*8 +: 8];
      for (int i = 0; i < 8; i++) ee[i] = !(i == digit && enb[i]);
      ed  = frame[m_owner*64 + digit*8 +: 8];
    end
    check("grant", 32'(grant), 32'(eg));
    check("targeten", 32'(targeten), 32'(ee));
    check("targetdisplay", 32'(targetdisplay), 32'(ed));
    check("frame_end", 32'(frame_end), 32'(m_phase == FLEN - 1));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clock);
      #1 check_outputs();
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++)
      for (int d = 0; d < 8; d++)
        frame[k*64 + d*8 +: 8] = {2'(k), 3'(d), 3'b000};

    // Reset held, then released with no requests.
    run(2);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_en", 32'(targeten), 32'hFF);
    rst = 1'b1;
    run(5);
    check("idle_grant", 32'(grant), 32'h0);

    // Grant from IDLE, digit stepping, frame_end timing.
    req = 4'b0010;
    run(1);
    check("s2_grant", 32'(grant), 32'h2);
    check("s2_en0", 32'(targeten), 32'hFE);
    check("s2_disp0", 32'(targetdisplay), 32'h40);
    run(2);
    check("s2_en1", 32'(targeten), 32'hFD);
    run(13);
    check("s2_frame_end", 32'(frame_end), 32'h1);

    // Hold for two frames, then rotate to source 2.
    req = 4'b0110;
    run(1);
    check("s3_keep", 32'(grant), 32'h2);
    run(16);
    check("s3_rotate", 32'(grant), 32'h4);

    // Urgent request mid-frame takes over at frame end and keeps the display.
    run(6);
    req = 4'b0111;
    run(9);
    check("s4_before", 32'(grant), 32'h4);
    run(1);
    check("s4_urgent", 32'(grant), 32'h1);
    run(4 * FLEN);
    check("s4_keep", 32'(grant), 32'h1);

    // Release to source 3, drop mid-frame, go idle, re-request.
    req = 4'b1000;
    run(FLEN + 1);
    check("s5_owner3", 32'(grant), 32'h8);
    run(5);
    req = 4'b0000;
    run(FLEN);
    check("s5_idle", 32'(grant), 32'h0);
    check("s5_idle_en", 32'(targeten), 32'hFF);
    run(3);
    req = 4'b1000;
    run(1);
    check("s5_regrant", 32'(grant), 32'h8);

    // Partial enable mask on source 1.
    en_bus[15:8] = 8'hFC;
    req = 4'b0010;
    run(FLEN + 1);
    check("s6_owner1", 32'(grant), 32'h2);
    run(2 * FLEN);

    // Asynchronous reset mid-SHOW clears outputs within the cycle.
    @(negedge clock);
    #2 rst = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'h0);
    check("arst_en", 32'(targeten), 32'hFF);
    check("arst_disp", 32'(targetdisplay), 32'hFF);
    check("arst_fe", 32'(frame_end), 32'h0);
    run(2);
    req = 4'b0000;
    rst = 1'b1;
    run(5);
    check("arst_idle", 32'(grant), 32'h0);

    // Randomized traffic.
    repeat (80) begin
      case ($urandom_range(0, 5))
        0: req = 4'd0;
        1: req = 4'b0001 << $urandom_range(0, 3);
        default: req = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 3) == 0) en_bus = $urandom;
      if ($urandom_range(0, 5) == 0) frame[$urandom_range(0, 31)*8 +: 8] = 8'($urandom);
      if ($urandom_range(0, 20) == 0) begin
        rst = 1'b0;
        run(1);
        rst = 1'b1;
      end
      run($urandom_range(1, 3 * FLEN));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_arbiter.md
# seg_scan_arbiter

Shares the single 8-digit seven-segment scan port (HEX/AN) between four display sources: timer, clock, alarm set-up and an urgent alert overlay. It performs the digit multiplexing itself and arbitrates ownership of the display. Ownership changes only at frame boundaries, so a frame is never torn. It sits between the per-mode display controllers and the board HEX/AN pins, and replaces mode-indexed muxing of per-module scanners.

## Interface
- SCAN_DIV, 5000: clock cycles per digit slot; ≥1.
- HOLD_FRAMES, 4: minimum complete frames an owner keeps the display while other sources request; 1..255.
- clock  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  4  display request per source; bit 0 is the urgent source.
- en_bus  in  32  digit enable mask, active-high; source k uses bits [8k+7:8k].
- frame  in  256  segment patterns, active-low; source k digit d uses bits [64k+8d+7:64k+8d].
- grant  out  4  one-hot current owner; 0 when idle.
- targeten  out  8  digit anodes, active-low.
- targetdisplay  out  8  segment pattern for the selected digit.
- frame_end  out  1  one-cycle pulse on the last cycle of digit 7.

## Operation
- Internal registers:
  - div: counts 0..SCAN_DIV-1.
  - select: 3 bits, current digit.
  - owner: 2 bits, plus an owner-valid flag.
  - held: 8 bits, saturating.
  - rr: 2 bits, last round-robin winner.
- tick = (div == SCAN_DIV-1). On tick, div returns to 0 and select increments, wrapping 7→0.
- frame_end = tick && select == 7.
- The scanner runs continuously in both states.
- States:
  - IDLE: grant = 0, targeten = 8'hFF, targetdisplay = 8'hFF.
  - SHOW: grant = 1 << owner. targeten = ~(8'b1 << select) | ~en_k. targetdisplay = frame digit select of owner.
  - In SHOW, targeten and targetdisplay are combinational from registered select and owner and the live inputs.
- IDLE → SHOW on any clock edge with req != 0:
  - Winner is req[0] if set, else the first set bit searching rr+1, rr+2, … modulo 4.
  - The same edge loads owner and rr, sets held = 0, div = 0 and select = 0.
- In SHOW, no change except at frame_end. At frame_end, the first matching rule applies:
  1. req[0] && owner != 0 → owner = 0, held = 0.
  2. !req[owner]: if other requests exist, pick the round-robin winner from owner+1 and set held = 0; if none, go to IDLE.
  3. held + 1 ≥ HOLD_FRAMES and another req[j], j != owner, is set → round-robin winner from owner+1, held = 0.
  4. Otherwise keep the owner; held = min(held + 1, 255).
- Source 0 is never rotated away from by rule 3 while req[0] stays high; it keeps the display.
- rr is updated on every grant.
- A req pulse shorter than a frame while in SHOW is ignored.
- rst low at any time clears all registers immediately:
  - div = 0, select = 0, owner invalid, held = 0, rr = 3.
  - Outputs: grant = 0, targeten = 8'hFF, targetdisplay = 8'hFF, frame_end = 0.

## Timing
- Grant latency from IDLE: 1 cycle. Digit 0 of the new owner is shown for a full SCAN_DIV cycles starting that edge.
- Handover in SHOW: the new owner appears on the edge following frame_end. That edge also begins digit 0, because select wraps on the same tick.
- Frame length: 8·SCAN_DIV cycles.
- Worst-case urgent latency: 8·SCAN_DIV cycles.
- Frame and en changes from the owner are visible on the same cycle (no registering).
- Release latency: the owner dropping req completes the current frame, then the block goes IDLE or hands over.

## Test plan
Settings for all scenarios: SCAN_DIV = 2, HOLD_FRAMES = 2, all en = 8'hFF, source k digit d pattern = {k, d[2:0], 3'b0} style unique values.
1. Reset: assert rst mid-SHOW → same cycle grant = 0, targeten = 8'hFF, targetdisplay = 8'hFF. After release with req = 0, the block stays IDLE.
2. IDLE, req = 4'b0010 at edge t → at t+1 grant = 4'b0010, targeten = 8'hFE, targetdisplay = source 1 digit 0. targeten becomes 8'hFD at t+3; frame_end pulses at t+16.
3. Owner 1 with req = 4'b0110 held → owner stays through 2 frames, then grant = 4'b0100 on the edge after the second frame_end (t+33).
4. Owner 2 in frame 1 (held = 0), req[0] rises at digit 3 → grant = 4'b0001 right after that frame's end; held is ignored. Source 0 then keeps the display while req = 4'b0111.
5. Owner 3 drops req mid-frame with no other requests → digits keep scanning source 3 until frame_end, then IDLE (targeten = 8'hFF). A new req = 4'b1000 later → grant = 4'b1000 after 1 cycle.
6. Owner 1 with en = 8'hFC → targeten = 8'hFF while select = 0 or 1, and 8'hFB at select = 2.
